dram_arbiter: RTL and testbench

- Round-robin arbiter that shares one DRAM instance (single write port, single synchronous read port) between NUM_REQ requesters, e.g. weight loader, activation loader and output writer.
- Requesters use a valid/ready command handshake and receive read data on a per-requester response strobe.
- The arbiter registers all DRAM command signals and tracks in-flight reads so each response returns to the requester that issued it.

---
 rtl/dram_arb_pkg.sv | 23 ++
 rtl/dram_arbiter_rr_arbiter.sv | 53 +++++
 rtl/dram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter slice.
// Requester ids are sized for the largest supported requester count so the
// in-flight record layout does not depend on the instance parameters.
package dram_arb_pkg;

    localparam int NUM_REQ_MAX    = 8;
    localparam int ID_W           = $clog2(NUM_REQ_MAX);
    localparam int RD_LATENCY_MAX = 4;

    // One slot of the read-return pipeline: which requester a read belongs to.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } inflight_t;

    // Next requester index after idx, wrapping at modulus.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int modulus);
        logic [ID_W:0] nxt;
        nxt = {1'b0, idx} + {{ID_W{1'b0}}, 1'b1};
        wrap_inc = (nxt >= (ID_W+1)'(modulus)) ? {ID_W{1'b0}} : nxt[ID_W-1:0];
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection.
// Scans requests starting at ptr with wrap-around; while lock_active is set
// only lock_id may win. The pointer register lives in the parent.
module rr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               lock_active,
    input  logic [ID_W-1:0]    lock_id,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W:0] pos_s;

    // Pick the first requesting index at or after ptr, or the locked owner.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos_s       = '0;
        if (lock_active) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (lock_id == ID_W'(j))) begin
                    grant[j]    = 1'b1;
                    grant_idx   = ID_W'(j);
                    grant_valid = 1'b1;
                end else begin
                    grant[j] = grant[j];
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pos_s = {1'b0, ptr} + (ID_W+1)'(i);
                pos_s = (pos_s >= (ID_W+1)'(NUM_REQ)) ? (pos_s - (ID_W+1)'(NUM_REQ)) : pos_s;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!grant_valid && req[j] && (pos_s == (ID_W+1)'(j))) begin
                        grant[j]    = 1'b1;
                        grant_idx   = ID_W'(j);
                        grant_valid = 1'b1;
                    end else begin
                        grant[j] = grant[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM (one write port, one synchronous read
// port) between NUM_REQ requesters. All DRAM command signals are registered;
// a shift register of depth RD_LATENCY remembers which requester owns each
// outstanding read so the response strobe goes back to the issuer.
// Optional build macro DRAM_ARB_LOCK_EN adds req_lock: a requester granted
// with its lock bit set keeps exclusive access until it drops the bit.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                          CLK,
    input  logic                          ASYNC_RST,
    input  logic                          SYNC_RST,
    input  logic                          EN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef DRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          dram_en,
    output logic                          wren,
    output logic [ADDR_WIDTH-1:0]         wraddr,
    output logic [DATA_WIDTH-1:0]         wrdata,
    output logic [ADDR_WIDTH-1:0]         rdaddr,
    input  logic [DATA_WIDTH-1:0]         rddata
);

    logic [NUM_REQ-1:0]    grant_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic                  grant_valid_s;
    logic [ID_W-1:0]       ptr_r;
    logic                  lock_active_s;
    logic [ID_W-1:0]       lock_id_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    inflight_t             push_s;
    inflight_t             head_s;
    inflight_t [RD_LATENCY-1:0] pipe_r;
    logic [NUM_REQ-1:0]    rsp_hot_s;

    // Masking requests with EN means a disabled cycle yields no grant at all.
    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr (
        .req         (req_valid & {NUM_REQ{EN}}),
        .ptr         (ptr_r),
        .lock_active (lock_active_s),
        .lock_id     (lock_id_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    assign req_ready = grant_s;
    assign dram_en   = EN;
    assign head_s    = pipe_r[RD_LATENCY-1];

`ifdef DRAM_ARB_LOCK_EN
    logic            lock_r;
    logic [ID_W-1:0] lock_id_r;
    logic            lock_held_s;
    logic            grant_lock_s;

    // Is the lock owner still asserting its lock, and does this grant take one.
    always_comb begin
        lock_held_s  = 1'b0;
        grant_lock_s = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            lock_held_s  = lock_held_s | (req_lock[j] & (lock_id_r == ID_W'(j)));
            grant_lock_s = grant_lock_s | (req_lock[j] & grant_s[j]);
        end
    end

    // The lock is effective only while the owner keeps its bit high, so the
    // cycle it falls is already arbitrated round-robin from owner+1.
    assign lock_active_s = lock_r & lock_held_s;
    assign lock_id_s     = lock_id_r;

    // Lock ownership register.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            lock_r    <= 1'b0;
            lock_id_r <= '0;
        end else if (SYNC_RST) begin
            lock_r    <= 1'b0;
            lock_id_r <= '0;
        end else if (EN) begin
            if (grant_valid_s && grant_lock_s) begin
                lock_r    <= 1'b1;
                lock_id_r <= grant_idx_s;
            end else if (!lock_active_s) begin
                lock_r    <= 1'b0;
            end
        end
    end
`else
    assign lock_active_s = 1'b0;
    assign lock_id_s     = '0;
`endif

    // AND-OR mux of the granted requester's command fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sel_we_s    = sel_we_s | (req_we[j] & grant_s[j]);
            sel_addr_s  = sel_addr_s | (req_addr[j*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[j]}});
            sel_wdata_s = sel_wdata_s | (req_wdata[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[j]}});
        end
    end

    // Decode the pipeline head into a one-hot response strobe.
    always_comb begin
        push_s.valid = grant_valid_s & ~sel_we_s;
        push_s.id    = grant_idx_s;
        rsp_hot_s    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rsp_hot_s[j] = head_s.valid & (head_s.id == ID_W'(j));
        end
    end

    // Round-robin pointer: the index after the last winner. While a lock is
    // held this already points past the owner, which is where scanning must
    // resume once the lock falls.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            ptr_r <= '0;
        end else if (SYNC_RST) begin
            ptr_r <= '0;
        end else if (grant_valid_s) begin
            ptr_r <= wrap_inc(grant_idx_s, NUM_REQ);
        end
    end

    // Registered DRAM command port; everything holds while EN is low.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            wren   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
            rdaddr <= '0;
        end else if (SYNC_RST) begin
            wren   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
            rdaddr <= '0;
        end else if (EN) begin
            if (grant_valid_s && sel_we_s) begin
                wren   <= 1'b1;
                wraddr <= sel_addr_s;
                wrdata <= sel_wdata_s;
            end else begin
                wren <= 1'b0;
                if (grant_valid_s) begin
                    rdaddr <= sel_addr_s;
                end
            end
        end
    end

    // In-flight read tracking; one slot per DRAM read-latency cycle.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            pipe_r <= '0;
        end else if (SYNC_RST) begin
            pipe_r <= '0;
        end else if (EN) begin
            pipe_r[0] <= push_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Registered read response; data bus keeps its last value between strobes.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (SYNC_RST) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (EN) begin
            rsp_valid <= rsp_hot_s;
            if (head_s.valid) begin
                rsp_rdata <= rddata;
            end
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter with default parameters
// (3 requesters, 4-bit address, 8-bit data, read latency 1). A small DRAM
// model sits on the command port; its read data follows rdaddr directly.
// Define DRAM_ARB_LOCK_EN to also exercise the lock feature.
module tb_dram_arbiter;

    logic        CLK;
    logic        ASYNC_RST;
    logic        SYNC_RST;
    logic        EN;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [11:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  req_lock;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        dram_en;
    logic        wren;
    logic [3:0]  wraddr;
    logic [7:0]  wrdata;
    logic [3:0]  rdaddr;
    logic [7:0]  rddata;

    logic [7:0]  mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    dram_arbiter dut (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .SYNC_RST  (SYNC_RST),
        .EN        (EN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DRAM_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .dram_en   (dram_en),
        .wren      (wren),
        .wraddr    (wraddr),
        .wrdata    (wrdata),
        .rdaddr    (rdaddr),
        .rddata    (rddata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Known preload contents of the DRAM model.
    function automatic logic [7:0] exp_mem(input int a);
        return 8'h80 + 8'(a * 17);
    endfunction

    // DRAM model: preloaded during reset, commits writes on the edge after wren.
    always @(posedge CLK) begin
        if (ASYNC_RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= exp_mem(i);
        end else if (dram_en && wren) begin
            mem[wraddr] <= wrdata;
        end
    end
    assign rddata = mem[rdaddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        req_valid[r]         = 1'b1;
        req_we[r]            = we;
        req_addr[r*4 +: 4]   = addr;
        req_wdata[r*8 +: 8]  = wd;
    endtask

    initial begin
        ASYNC_RST = 1'b1;
        SYNC_RST  = 1'b0;
        EN        = 1'b1;
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_addr  = 12'h000;
        req_wdata = 24'h000000;
        req_lock  = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_wren", wren, 32'd0);
        check_eq("rst_wraddr", wraddr, 32'd0);
        check_eq("rst_wrdata", wrdata, 32'd0);
        check_eq("rst_rdaddr", rdaddr, 32'd0);
        check_eq("rst_rsp_valid", rsp_valid, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        ASYNC_RST = 1'b0;

        // Single write then read of address 3 by requester 0.
        set_req(0, 1'b1, 4'd3, 8'hA5);
        #1;
        check_eq("wr_ready", req_ready, 32'b001);
        step();
        check_eq("wr_wren", wren, 32'd1);
        check_eq("wr_wraddr", wraddr, 32'd3);
        check_eq("wr_wrdata", wrdata, 32'hA5);
        set_req(0, 1'b0, 4'd3, 8'h00);
        #1;
        check_eq("rd_ready", req_ready, 32'b001);
        step();
        req_valid = 3'b000;
        check_eq("rd_wren", wren, 32'd0);
        check_eq("rd_rdaddr", rdaddr, 32'd3);
        check_eq("rd_rsp_early", rsp_valid, 32'd0);
        step();
        check_eq("rd_rsp_valid", rsp_valid, 32'b001);
        check_eq("rd_rsp_rdata", rsp_rdata, 32'hA5);
        step();
        check_eq("rd_rsp_drop", rsp_valid, 32'd0);
        check_eq("rd_rdata_hold", rsp_rdata, 32'hA5);

        // Synchronous clear: same effect as reset at the next edge.
        SYNC_RST = 1'b1;
        step();
        SYNC_RST = 1'b0;
        check_eq("srst_wraddr", wraddr, 32'd0);
        check_eq("srst_wrdata", wrdata, 32'd0);
        check_eq("srst_rdaddr", rdaddr, 32'd0);
        check_eq("srst_rsp_rdata", rsp_rdata, 32'd0);

        // Fairness: all three read continuously, grants rotate 0,1,2,0,1,2.
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                for (int r = 0; r < 3; r++) set_req(r, 1'b0, 4'(r), 8'h00);
            end else begin
                req_valid = 3'b000;
            end
            #1;
            check_eq("fair_ready", req_ready, (k < 6) ? (32'd1 << (k % 3)) : 32'd0);
            if (k >= 1 && k <= 6) check_eq("fair_rdaddr", rdaddr, 32'((k - 1) % 3));
            if (k >= 2) begin
                check_eq("fair_rsp_valid", rsp_valid, 32'd1 << ((k - 2) % 3));
                check_eq("fair_rsp_rdata", rsp_rdata, 32'(exp_mem((k - 2) % 3)));
            end
            step();
        end

        // Read-after-write: req1 writes addr 5, req2 reads it the next cycle.
        set_req(1, 1'b1, 4'd5, 8'h3C);
        #1;
        check_eq("raw_wr_ready", req_ready, 32'b010);
        step();
        req_valid = 3'b000;
        set_req(2, 1'b0, 4'd5, 8'h00);
        #1;
        check_eq("raw_rd_ready", req_ready, 32'b100);
        step();
        req_valid = 3'b000;
        step();
        check_eq("raw_rsp_valid", rsp_valid, 32'b100);
        check_eq("raw_rsp_rdata", rsp_rdata, 32'h3C);

        // EN stall for three cycles with a read in flight.
        set_req(0, 1'b0, 4'd1, 8'h00);
        #1;
        check_eq("stall_ready", req_ready, 32'b001);
        step();
        req_valid = 3'b000;
        set_req(1, 1'b0, 4'd2, 8'h00);
        EN = 1'b0;
        #1;
        check_eq("stall_no_grant", req_ready, 32'd0);
        check_eq("stall_dram_en", dram_en, 32'd0);
        check_eq("stall_rsp0", rsp_valid, 32'd0);
        step();
        check_eq("stall_rsp1", rsp_valid, 32'd0);
        step();
        check_eq("stall_rsp2", rsp_valid, 32'd0);
        step();
        check_eq("stall_rsp3", rsp_valid, 32'd0);
        check_eq("stall_rdaddr", rdaddr, 32'd1);
        req_valid = 3'b000;
        EN = 1'b1;
        step();
        check_eq("stall_rsp_valid", rsp_valid, 32'b001);
        check_eq("stall_rsp_rdata", rsp_rdata, 32'(exp_mem(1)));

        // Asynchronous reset with two reads in flight.
        set_req(0, 1'b0, 4'd2, 8'h00);
        #1;
        check_eq("mrst_rd0_ready", req_ready, 32'b001);
        step();
        req_valid = 3'b000;
        set_req(1, 1'b0, 4'd7, 8'h00);
        #1;
        check_eq("mrst_rd1_ready", req_ready, 32'b010);
        step();
        req_valid = 3'b000;
        check_eq("mrst_pre_rsp", rsp_valid, 32'b001);
        #2;
        ASYNC_RST = 1'b1;
        #1;
        check_eq("mrst_rsp_valid", rsp_valid, 32'd0);
        check_eq("mrst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("mrst_rdaddr", rdaddr, 32'd0);
        check_eq("mrst_wraddr", wraddr, 32'd0);
        check_eq("mrst_wrdata", wrdata, 32'd0);
        check_eq("mrst_wren", wren, 32'd0);
        @(posedge CLK);
        #1;
        ASYNC_RST = 1'b0;
        check_eq("mrst_after0", rsp_valid, 32'd0);
        step();
        check_eq("mrst_after1", rsp_valid, 32'd0);
        step();
        check_eq("mrst_after2", rsp_valid, 32'd0);
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, 4'(r), 8'h00);
        #1;
        check_eq("mrst_first_grant", req_ready, 32'b001);
        step();
        req_valid = 3'b000;

`ifdef DRAM_ARB_LOCK_EN
        // Lock: req1 keeps exclusive access while req_lock[1] is high.
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, 4'(r), 8'h00);
        req_lock = 3'b010;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("lock_grant", req_ready, 32'b010);
            step();
        end
        req_valid[1] = 1'b0;
        #1;
        check_eq("lock_idle_owner", req_ready, 32'd0);
        step();
        req_valid[1] = 1'b1;
        req_lock     = 3'b000;
        #1;
        check_eq("lock_release", req_ready, 32'b100);
        step();
        req_valid = 3'b000;
`endif

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
